// File: rtl/uart_tx_frame_if.sv
// Word handshake between the upstream producer and the UART transmit framer.
// The producer is the master; the framer is the slave.
interface uart_tx_frame_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: paces start, data (LSB first), optional parity and stop
// bits on the bps_clk pulses of an external baud generator that it starts and stops.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_frame_if.slave tx_if,
  input  logic           bps_clk,
  output logic           tx_start,
  output logic           tx_done,
  output logic           uart_tx,
  output logic           busy
);

  localparam int unsigned CNT_W   = $clog2(DATA_WIDTH + 1);
  localparam bit          PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit          PAR_ODD = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  par_q, par_d;
  logic                  line_q, line_d;
  logic                  ready_q, ready_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  accept;

  // ready_q is only ever high in IDLE, so it alone qualifies acceptance.
  assign accept = tx_if.tx_valid && ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      line_q     <= 1'b1;
      ready_q    <= 1'b1;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      line_q     <= line_d;
      ready_q    <= ready_d;
      start_q    <= start_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    line_d     = line_q;
    ready_d    = ready_q;
    start_d    = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // ready returns one cycle after the tx_done pulse, not with it
        if (done_q) begin
          ready_d = 1'b1;
        end
        if (accept) begin
          shift_d = tx_if.tx_data;
          par_d   = PAR_ODD ? ~(^tx_if.tx_data) : ^tx_if.tx_data;
          start_d = 1'b1;
          ready_d = 1'b0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bps_clk) begin
          line_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (bps_clk) begin
          if (cnt_q == CNT_W'(DATA_WIDTH)) begin
            stop_cnt_d = 1'b0;
            if (PAR_EN) begin
              line_d  = par_q;
              state_d = S_PARITY;
            end else begin
              line_d  = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            line_d  = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      S_PARITY: begin
        if (bps_clk) begin
          line_d     = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end

      S_STOP: begin
        if (bps_clk) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign tx_if.tx_ready = ready_q;
  assign busy           = ~ready_q;
  assign tx_start       = start_q;
  assign tx_done        = done_q;
  assign uart_tx        = line_q;

  a_start_done_excl: assert property (@(posedge clk) disable iff (rst)
    !(start_q && done_q));
  a_start_single: assert property (@(posedge clk) disable iff (rst)
    start_q |=> !start_q);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomized bench for uart_tx_frame: several parameter sets, each checked against
// a frame model that lists the expected line level per bit period.
module tb_uart_tx_frame;

  localparam int NDUT = 5;

  function automatic int par_of(input int k);
    case (k)
      1:       return 2;
      2:       return 1;
      4:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int sb_of(input int k);
    return (k >= 3) ? 2 : 1;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0] rst_a, valid_a, bps_a;
  logic [NDUT-1:0] start_a, done_a, line_a, busy_a, ready_a;
  logic [7:0]      data_a [NDUT];

  int n_checks = 0;
  int n_errors = 0;
  int cur_k    = 0;

  genvar g;
  for (g = 0; g < NDUT; g++) begin : g_dut
    uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();
    assign bus.tx_data  = data_a[g];
    assign bus.tx_valid = valid_a[g];
    assign ready_a[g]   = bus.tx_ready;

    uart_tx_frame #(
      .DATA_WIDTH(8),
      .PARITY    (par_of(g)),
      .STOP_BITS (sb_of(g))
    ) dut (
      .clk     (clk),
      .rst     (rst_a[g]),
      .tx_if   (bus),
      .bps_clk (bps_a[g]),
      .tx_start(start_a[g]),
      .tx_done (done_a[g]),
      .uart_tx (line_a[g]),
      .busy    (busy_a[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h", cur_k, tag, got, exp);
    end
  endtask

  // Parity bit from the definition: total ones over data+parity odd/even.
  function automatic bit par_bit(input int k, input logic [7:0] d);
    int ones;
    ones = $countones(d);
    if (par_of(k) == 1) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  task automatic pulse(input int k);
    bps_a[k] = 1'b1;
    @(negedge clk);
    bps_a[k] = 1'b0;
  endtask

  task automatic accept(input int k, input logic [7:0] d, input bit spur, input bit now);
    int n;
    n = 0;
    valid_a[k] = 1'b1;
    data_a[k]  = d;
    while (ready_a[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 20), 1);
    if (now) chk("b2b_accept_delay", n, 0);
    bps_a[k] = spur;
    @(negedge clk);
    bps_a[k]   = 1'b0;
    valid_a[k] = 1'b0;
    data_a[k]  = 8'($urandom);
    chk("start_pulse", start_a[k], 1);
    chk("ready_low", ready_a[k], 0);
    chk("busy_high", busy_a[k], 1);
    chk("line_after_accept", line_a[k], 1);
  endtask

  task automatic idle(input int k, input int cycles);
    valid_a[k] = 1'b0;
    repeat (cycles) begin
      bps_a[k] = 1'($urandom_range(0, 1));
      @(negedge clk);
      bps_a[k] = 1'b0;
      chk("idle_line", line_a[k], 1);
      chk("idle_ready", ready_a[k], 1);
      chk("idle_start", start_a[k], 0);
      chk("idle_done", done_a[k], 0);
    end
  endtask

  task automatic mid_reset(input int k);
    valid_a[k] = 1'b0;
    rst_a[k]   = 1'b1;
    @(negedge clk);
    rst_a[k] = 1'b0;
    chk("rst_line", line_a[k], 1);
    chk("rst_ready", ready_a[k], 1);
    chk("rst_busy", busy_a[k], 0);
    chk("rst_done", done_a[k], 0);
    chk("rst_start", start_a[k], 0);
    repeat (4) begin
      pulse(k);
      chk("post_rst_done", done_a[k], 0);
      chk("post_rst_line", line_a[k], 1);
      chk("post_rst_start", start_a[k], 0);
    end
  endtask

  // Entered in the tx_start cycle; rst_at > 0 resets after that bps pulse.
  task automatic frame(input int k, input logic [7:0] d, input bit noise, input int rst_at,
                       input bit hold, input logic [7:0] nd);
    bit bits[$];
    int n;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (par_of(k) == 1 || par_of(k) == 2) bits.push_back(par_bit(k, d));
    for (int i = 0; i < sb_of(k); i++) bits.push_back(1'b1);
    n = bits.size() + 1;

    repeat ($urandom_range(1, 3)) begin
      @(negedge clk);
      chk("wait_start_pulse", start_a[k], 0);
      chk("wait_line", line_a[k], 1);
      chk("wait_busy", busy_a[k], 1);
    end

    for (int j = 1; j <= n; j++) begin
      pulse(k);
      if (j < n) begin
        chk("bit", line_a[k], 32'(bits[j-1]));
        chk("early_done", done_a[k], 0);
      end else begin
        chk("done", done_a[k], 1);
        chk("done_line", line_a[k], 1);
        chk("done_ready", ready_a[k], 0);
        chk("done_start", start_a[k], 0);
      end
      if (j == rst_at) begin
        mid_reset(k);
        return;
      end
      if (j < n) begin
        repeat ($urandom_range(0, 3)) begin
          if (noise) begin
            valid_a[k] = 1'($urandom_range(0, 1));
            data_a[k]  = 8'($urandom);
          end
          @(negedge clk);
          chk("bit_hold", line_a[k], 32'(bits[j-1]));
          chk("busy_in_frame", busy_a[k], 1);
          chk("gap_done", done_a[k], 0);
          chk("gap_start", start_a[k], 0);
        end
      end
    end

    valid_a[k] = hold;
    data_a[k]  = nd;
    @(negedge clk);
    chk("done_single", done_a[k], 0);
    chk("ready_back", ready_a[k], 1);
    chk("line_after_done", line_a[k], 1);
  endtask

  initial begin
    logic [7:0] d, nxt;
    bit h;
    rst_a   = '1;
    valid_a = '0;
    bps_a   = '0;
    for (int k = 0; k < NDUT; k++) data_a[k] = '0;
    repeat (3) @(negedge clk);
    rst_a = '0;

    for (int k = 0; k < NDUT; k++) begin
      cur_k = k;
      chk("reset_line", line_a[k], 1);
      chk("reset_ready", ready_a[k], 1);
      chk("reset_busy", busy_a[k], 0);
      chk("reset_start", start_a[k], 0);
      chk("reset_done", done_a[k], 0);

      accept(k, 8'hA5, 1'b0, 1'b0);
      frame(k, 8'hA5, 1'b0, 0, 1'b0, 8'h00);
      idle(k, 5);

      accept(k, 8'h00, 1'b0, 1'b0);
      frame(k, 8'h00, 1'b0, 0, 1'b0, 8'h00);
      idle(k, 2);

      accept(k, 8'h3C, 1'b0, 1'b0);
      frame(k, 8'h3C, 1'b0, 0, 1'b1, 8'hC3);
      accept(k, 8'hC3, 1'b0, 1'b1);
      frame(k, 8'hC3, 1'b0, 0, 1'b0, 8'h00);
      idle(k, 4);

      d = 8'($urandom);
      accept(k, d, 1'b1, 1'b0);
      frame(k, d, 1'b1, 0, 1'b0, 8'h00);
      idle(k, 6);

      d = 8'($urandom);
      accept(k, d, 1'b0, 1'b0);
      frame(k, d, 1'b1, 5, 1'b0, 8'h00);
      d = 8'($urandom);
      accept(k, d, 1'b0, 1'b0);
      frame(k, d, 1'b0, 0, 1'b0, 8'h00);
      idle(k, 3);

      d = 8'($urandom);
      accept(k, d, 1'b0, 1'b0);
      for (int r = 0; r < 4; r++) begin
        nxt = 8'($urandom);
        h   = (r < 3) && ($urandom_range(0, 1) == 1);
        frame(k, d, 1'b1, 0, h, nxt);
        if (r < 3) begin
          if (!h) idle(k, 2);
          accept(k, nxt, 1'b0, h);
          d = nxt;
        end
      end
      idle(k, 3);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
